// File: rtl/div_pkg.sv
// Shared definitions for the HI/LO iterative divider: default width, FSM states
// and the conditional negate also used by the multiplier's signed path.
package div_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Two's-complement negate when neg is set; abs_val(x, x[MSB]) yields |x|.
  function automatic logic [WIDTH_DEFAULT-1:0] abs_val(
    input logic [WIDTH_DEFAULT-1:0] x,
    input logic                     neg
  );
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep or restore the partial remainder.
module divider_step
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The shifted remainder is below 2*divisor, so WIDTH+1 bits hold both it and
  // the trial difference; the top bit of the difference is its sign.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_iterative.sv
// Multi-cycle signed/unsigned restoring divider for the HI/LO unit: one quotient
// bit per clock, results held in q/r and flagged by a one-cycle valid_out pulse.
module divider_iterative
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid_out,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;      // dividend bits shift out the top, quotient bits in at the bottom
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .divisor (divisor),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd       <= '0;
      rem       <= '0;
      divisor   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      q         <= '0;
      r         <= '0;
      valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            dvd     <= abs_val(a, signed_op & a[WIDTH-1]);
            divisor <= abs_val(b, signed_op & b[WIDTH-1]);
            neg_q   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r   <= signed_op & a[WIDTH-1];
            rem     <= '0;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          rem <= rem_next;
          dvd <= {dvd[WIDTH-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          // Magnitude results get the sign back: quotient by operand signs,
          // remainder by dividend sign (C truncation).
          q         <= abs_val(dvd, neg_q);
          r         <= abs_val(rem, neg_r);
          valid_out <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          valid_out <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_iterative.sv
// Self-checking bench for divider_iterative: directed vector table, multi-cycle
// handshake corner cases and a swept/random comparison against arithmetic.
module tb_divider_iterative;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        signed_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        valid_out;
  logic [31:0] q;
  logic [31:0] r;

  int checks = 0;
  int errors = 0;

  divider_iterative dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .valid_out (valid_out),
    .q         (q),
    .r         (r)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain arithmetic reference: C-style truncating division, divide-by-zero
  // returns all-ones magnitude with the usual sign fix applied.
  function automatic void model(input logic [31:0] aa, input logic [31:0] bb, input logic s,
                                output logic [31:0] eq, output logic [31:0] er);
    longint sa;
    longint sb;
    if (!s) begin
      if (bb == 0) begin
        eq = 32'hFFFF_FFFF;
        er = aa;
      end else begin
        eq = aa / bb;
        er = aa % bb;
      end
    end else begin
      sa = $signed(aa);
      sb = $signed(bb);
      if (sb == 0) begin
        eq = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
        er = aa;
      end else begin
        eq = 32'(sa / sb);
        er = 32'(sa % sb);
      end
    end
  endfunction

  // Present one request on the next edge; returns just after the accepting edge.
  task automatic launch(input logic [31:0] aa, input logic [31:0] bb, input logic s);
    @(negedge clk);
    valid_in  = 1'b1;
    a         = aa;
    b         = bb;
    signed_op = s;
    @(negedge clk);
    valid_in  = 1'b0;
    a         = $urandom;
    b         = $urandom;
    signed_op = 1'($urandom);
  endtask

  // Watch a fixed 36-cycle window after acceptance and report what came out.
  task automatic collect(output logic [31:0] qq, output logic [31:0] rr,
                         output int lat, output int vo_cnt, output int busy_cnt);
    lat      = -1;
    vo_cnt   = 0;
    busy_cnt = busy ? 1 : 0;
    qq       = '0;
    rr       = '0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (valid_out) begin
        vo_cnt++;
        if (lat < 0) begin
          lat = k;
          qq  = q;
          rr  = r;
        end
      end
    end
  endtask

  task automatic do_op(input string name, input logic [31:0] aa, input logic [31:0] bb,
                       input logic s, input logic [31:0] eq, input logic [31:0] er);
    logic [31:0] qq;
    logic [31:0] rr;
    int          lat;
    int          vo_cnt;
    int          busy_cnt;
    launch(aa, bb, s);
    collect(qq, rr, lat, vo_cnt, busy_cnt);
    check({name, ".q"}, qq, eq);
    check({name, ".r"}, rr, er);
    check({name, ".latency"}, lat, 33);
    check({name, ".pulses"}, vo_cnt, 1);
    check({name, ".busy_cycles"}, busy_cnt, 34);
  endtask

  task automatic check_props(input logic [31:0] aa, input logic [31:0] bb, input logic s);
    logic [31:0] qq;
    logic [31:0] rr;
    logic [63:0] recon;
    longint      mr;
    longint      mb;
    qq = q;
    rr = r;
    if (s) begin
      recon = {32'b0, 32'(qq * bb + rr)};
      check("prop.identity_s", recon, {32'b0, aa});
      mr = $signed(rr);
      mb = $signed(bb);
      if (mr < 0) mr = -mr;
      if (mb < 0) mb = -mb;
      check("prop.rem_mag_s", 64'(mr < mb), 64'd1);
      check("prop.rem_sign", 64'(rr == 0 || rr[31] == aa[31]), 64'd1);
    end else begin
      recon = {32'b0, qq} * {32'b0, bb} + {32'b0, rr};
      check("prop.identity_u", recon, {32'b0, aa});
      check("prop.rem_mag_u", 64'(rr < bb), 64'd1);
    end
  endtask

  vec_t vecs [9];

  initial begin
    logic [31:0] qq;
    logic [31:0] rr;
    logic [31:0] eq;
    logic [31:0] er;
    logic [31:0] aa;
    logic [31:0] bb;
    int          lat;
    int          vo_cnt;
    int          busy_cnt;

    vecs[0] = '{32'd100,         32'd7,           1'b0, 32'd14,          32'd2};
    vecs[1] = '{-32'd100,        32'd7,           1'b1, -32'd14,         -32'd2};
    vecs[2] = '{32'd100,         -32'd7,          1'b1, -32'd14,         32'd2};
    vecs[3] = '{-32'd100,        -32'd7,          1'b1, 32'd14,          -32'd2};
    vecs[4] = '{32'hFFFF_FFFF,   32'd1,           1'b0, 32'hFFFF_FFFF,   32'd0};
    vecs[5] = '{32'h8000_0000,   32'hFFFF_FFFF,   1'b1, 32'h8000_0000,   32'd0};
    vecs[6] = '{32'd5,           32'd0,           1'b0, 32'hFFFF_FFFF,   32'd5};
    vecs[7] = '{32'd7,           32'd0,           1'b1, 32'hFFFF_FFFF,   32'd7};
    vecs[8] = '{-32'd7,          32'd0,           1'b1, 32'd1,           -32'd7};

    reset     = 1'b1;
    valid_in  = 1'b0;
    signed_op = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    check("reset.busy", busy, 0);
    check("reset.valid_out", valid_out, 0);
    check("reset.q", q, 0);
    check("reset.r", r, 0);
    reset = 1'b0;

    foreach (vecs[i]) do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r);

    // Requests during RUN/FIX/DONE (and on the edge valid_out falls) are dropped;
    // the one on cycle 35 starts a new operation.
    launch(32'd100, 32'd7, 1'b0);
    a         = 32'd1000;
    b         = 32'd3;
    signed_op = 1'b0;
    lat       = -1;
    vo_cnt    = 0;
    qq        = '0;
    rr        = '0;
    for (int k = 1; k <= 35; k++) begin
      valid_in = (k == 1 || k == 20 || k == 33 || k == 34 || k == 35);
      @(negedge clk);
      if (valid_out) begin
        vo_cnt++;
        if (lat < 0) begin
          lat = k;
          qq  = q;
          rr  = r;
        end
      end
      if (k == 34) begin
        check("ignore.busy_after_done", busy, 0);
        check("ignore.q_hold", q, 32'd14);
        check("ignore.r_hold", r, 32'd2);
      end
    end
    valid_in = 1'b0;
    check("ignore.q", qq, 32'd14);
    check("ignore.r", rr, 32'd2);
    check("ignore.latency", lat, 33);
    check("ignore.pulses", vo_cnt, 1);
    check("ignore.accept35_busy", busy, 1);
    collect(qq, rr, lat, vo_cnt, busy_cnt);
    check("accept35.q", qq, 32'd333);
    check("accept35.r", rr, 32'd1);
    check("accept35.latency", lat, 33);

    // Reset asserted between edges 14 and 15 of a run clears everything at once.
    launch(32'd5000, 32'd9, 1'b0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset.busy", busy, 0);
    check("midreset.valid_out", valid_out, 0);
    check("midreset.q", q, 0);
    check("midreset.r", r, 0);
    @(negedge clk);
    reset  = 1'b0;
    vo_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid_out) vo_cnt++;
    end
    check("midreset.no_valid_out", vo_cnt, 0);
    do_op("after_reset", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);

    for (int i = 0; i < 100; i++) begin
      aa = i * 32'h2345_6789;
      bb = i * 32'h3456_7891;
      for (int s = 0; s < 2; s++) begin
        model(aa, bb, 1'(s), eq, er);
        do_op($sformatf("sweep%0d_s%0d", i, s), aa, bb, 1'(s), eq, er);
        if (bb != 0) check_props(aa, bb, 1'(s));
      end
    end

    for (int i = 0; i < 30; i++) begin
      aa = $urandom;
      bb = $urandom >> $urandom_range(0, 31);
      model(aa, bb, 1'(i % 2), eq, er);
      do_op($sformatf("rand%0d", i), aa, bb, 1'(i % 2), eq, er);
      if (bb != 0) check_props(aa, bb, 1'(i % 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
